// File: rtl/mac_tcdm_arbiter.sv
// Round-robin TCDM arbiter: NB_IN requesters onto one master port.
// Grant is locked while the slave stalls; an ID FIFO routes responses back.
module mac_tcdm_arbiter #(
  parameter int unsigned NB_IN = 4,
  parameter int unsigned OUTST = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [NB_IN-1:0]      in_req,
  output logic [NB_IN-1:0]      in_gnt,
  input  logic [NB_IN-1:0][31:0] in_add,
  input  logic [NB_IN-1:0]      in_wen,
  input  logic [NB_IN-1:0][3:0] in_be,
  input  logic [NB_IN-1:0][31:0] in_data,
  output logic [NB_IN-1:0][31:0] in_r_data,
  output logic [NB_IN-1:0]      in_r_valid,
  output logic                  out_req,
  input  logic                  out_gnt,
  output logic [31:0]           out_add,
  output logic                  out_wen,
  output logic [3:0]            out_be,
  output logic [31:0]           out_data,
  input  logic [31:0]           out_r_data,
  input  logic                  out_r_valid,
  output logic                  err_o
);

  localparam int unsigned IW = $clog2(NB_IN);
  localparam int unsigned CW = $clog2(OUTST + 1);
  localparam int unsigned PW = (OUTST > 1) ? $clog2(OUTST) : 1;

  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] lock_id_q, lock_id_d;
  logic          lock_q, lock_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [OUTST-1:0][IW-1:0] fifo_q, fifo_d;

  logic [IW-1:0] win, idx, head;
  logic          found, has_req;
  logic          full, empty, push, pop;

  always_comb begin
    win   = rr_q;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NB_IN; k++) begin
      idx = IW'((32'(rr_q) + k) % NB_IN);
      if (!found && in_req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    if (lock_q) win = lock_id_q;
  end

  assign has_req = in_req[win];
  assign full    = (cnt_q == CW'(OUTST));
  assign empty   = (cnt_q == '0);
  assign out_req = has_req & ~full;
  assign push    = out_req & out_gnt;
  assign pop     = out_r_valid & ~empty;
  assign head    = fifo_q[rptr_q];

  assign out_add  = has_req ? in_add[win]  : '0;
  assign out_wen  = has_req ? in_wen[win]  : 1'b0;
  assign out_be   = has_req ? in_be[win]   : '0;
  assign out_data = has_req ? in_data[win] : '0;

  assign in_r_data = {NB_IN{out_r_data}};
  assign err_o     = err_q;

  always_comb begin
    in_gnt      = '0;
    in_gnt[win] = push;
    in_r_valid  = '0;
    in_r_valid[head] = pop;
  end

  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q | (out_r_valid & empty);
    cnt_d     = cnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    fifo_d    = fifo_q;
    if (push) begin
      rr_d   = (win == IW'(NB_IN - 1)) ? '0 : win + IW'(1);
      lock_d = 1'b0;
      fifo_d[wptr_q] = win;
      wptr_d = (wptr_q == PW'(OUTST - 1)) ? '0 : wptr_q + PW'(1);
    end else if (out_req) begin
      lock_d    = 1'b1;
      lock_id_d = win;
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(OUTST - 1)) ? '0 : rptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // clear wins over every update in the same cycle
    if (clear_i) begin
      rr_d      = '0;
      lock_d    = 1'b0;
      lock_id_d = '0;
      err_d     = 1'b0;
      cnt_d     = '0;
      wptr_d    = '0;
      rptr_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      fifo_q    <= '0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fifo_q    <= fifo_d;
    end
  end

endmodule

// File: tb/tb_mac_tcdm_arbiter.sv
// Bench for mac_tcdm_arbiter: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_mac_tcdm_arbiter;
  localparam int NB = 4;
  localparam int OUTST = 2;

  logic clk = 1'b0;
  logic rst_ni, clear_i;
  logic [NB-1:0] in_req, in_gnt, in_wen, in_r_valid;
  logic [NB-1:0][31:0] in_add, in_data, in_r_data;
  logic [NB-1:0][3:0] in_be;
  logic out_req, out_gnt, out_wen, out_r_valid, err_o;
  logic [31:0] out_add, out_data, out_r_data;
  logic [3:0] out_be;

  mac_tcdm_arbiter #(.NB_IN(NB), .OUTST(OUTST)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add),
    .in_wen(in_wen), .in_be(in_be), .in_data(in_data),
    .in_r_data(in_r_data), .in_r_valid(in_r_valid),
    .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add),
    .out_wen(out_wen), .out_be(out_be), .out_data(out_data),
    .out_r_data(out_r_data), .out_r_valid(out_r_valid),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int m_rr, m_lock_id, g_idx;
  bit m_locked, m_err;
  int idq[$];
  logic [31:0] d1, d2;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_rr = 0; m_locked = 0; m_lock_id = 0; m_err = 0;
    idq.delete();
  endtask

  function automatic int win_m();
    if (m_locked) return m_lock_id;
    for (int k = 0; k < NB; k++)
      if (in_req[(m_rr + k) % NB]) return (m_rr + k) % NB;
    return -1;
  endfunction

  // one cycle: inputs already driven; check, advance model, move to next negedge
  task automatic step();
    int w;
    bit has, er, pop, push;
    logic [NB-1:0] eg, ev;
    logic [68:0] ef;
    #1;
    w = win_m();
    has = (w >= 0) ? in_req[w] : 1'b0;
    er = has && (idq.size() < OUTST);
    eg = '0;
    if (er && out_gnt) eg[w] = 1'b1;
    ef = has ? {in_wen[w], in_be[w], in_add[w], in_data[w]} : '0;
    ev = '0;
    if (out_r_valid && idq.size() > 0) ev[idq[0]] = 1'b1;
    chk("out_req", out_req, er);
    chk("in_gnt", in_gnt, eg);
    chk("out_fields", {out_wen, out_be, out_add, out_data}, ef);
    chk("in_r_valid", in_r_valid, ev);
    if (ev != '0) chk("in_r_data", in_r_data[idq[0]], out_r_data);
    chk("err_o", err_o, m_err);
    push = er && out_gnt;
    pop = out_r_valid && idq.size() > 0;
    g_idx = push ? w : -1;
    if (clear_i) begin
      m_reset();
    end else begin
      if (out_r_valid && idq.size() == 0) m_err = 1;
      if (pop) void'(idq.pop_front());
      if (push) begin
        idq.push_back(w);
        m_rr = (w + 1) % NB;
        m_locked = 0;
      end else if (er) begin
        m_locked = 1;
        m_lock_id = w;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_ni = 0; clear_i = 0; in_req = '0; out_gnt = 0;
    out_r_valid = 0; out_r_data = '0;
    for (int i = 0; i < NB; i++) begin
      in_add[i] = 32'hA000_0000 + 32'(i * 16);
      in_wen[i] = 1'(i);
      in_be[i] = 4'(i + 1);
      in_data[i] = 32'hD000_0000 + 32'(i);
    end
    m_reset();
    #12;
    chk("rst_gnt", in_gnt, 0);
    chk("rst_req", out_req, 0);
    chk("rst_rvalid", in_r_valid, 0);
    chk("rst_err", err_o, 0);
    rst_ni = 1;
    @(negedge clk);

    // fairness: all request, grant held high, response a cycle later
    in_req = '1; out_gnt = 1;
    for (int c = 0; c < 5; c++) begin
      out_r_valid = (c > 0);
      out_r_data = $urandom;
      step();
      chk("rr_seq", g_idx, c % NB);
    end
    in_req = '0; out_r_valid = 1; step();
    out_r_valid = 0; clear_i = 1; step();
    clear_i = 0;

    // lock while slave stalls
    in_req = 4'b0100; out_gnt = 0;
    repeat (3) begin
      #1 chk("lock_add", out_add, in_add[2]);
      step();
    end
    in_req = 4'b0101;
    #1 chk("lock_add_r0", out_add, in_add[2]);
    step();
    out_gnt = 1; step();
    chk("lock_gnt2", g_idx, 2);
    in_req = 4'b0001; step();
    chk("lock_gnt0", g_idx, 0);

    // FIFO full: two outstanding
    in_req = 4'b0010;
    #1 chk("full_req", out_req, 0);
    step();
    out_r_valid = 1; out_r_data = $urandom;
    #1 chk("full_pop_req", out_req, 0);
    chk("full_pop_rv", in_r_valid, 4'b0100);
    step();
    out_r_valid = 0;
    #1 chk("full_after_req", out_req, 1);
    step();
    in_req = '0; out_r_valid = 1; step(); step();
    out_r_valid = 0;

    // response routing with different latencies
    in_req = 4'b1000; step();
    chk("route_g3", g_idx, 3);
    d1 = $urandom; d2 = $urandom;
    in_req = 4'b0010; out_r_valid = 1; out_r_data = d1;
    #1 chk("route_rv3", in_r_valid, 4'b1000);
    chk("route_d3", in_r_data[3], d1);
    step();
    chk("route_g1", g_idx, 1);
    in_req = '0; out_r_valid = 0;
    repeat (3) step();
    out_r_valid = 1; out_r_data = d2;
    #1 chk("route_rv1", in_r_valid, 4'b0010);
    chk("route_d1", in_r_data[1], d2);
    step();
    out_r_valid = 0;

    // spurious response
    out_r_valid = 1;
    #1 chk("spur_rv", in_r_valid, 0);
    step();
    out_r_valid = 0;
    #1 chk("spur_err", err_o, 1);
    step(); step();
    clear_i = 1; step();
    clear_i = 0;
    #1 chk("spur_clr", err_o, 0);
    step();

    // random traffic
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      for (int i = 0; i < NB; i++) begin
        if (!in_req[i] || g_idx == i) begin
          in_req[i] = 1'($urandom_range(0, 1));
          in_add[i] = $urandom;
          in_wen[i] = 1'($urandom);
          in_be[i] = 4'($urandom);
          in_data[i] = $urandom;
        end
      end
      out_gnt = ($urandom_range(0, 3) != 0);
      out_r_valid = (idq.size() > 0) && ($urandom_range(0, 1) == 1);
      out_r_data = $urandom;
      clear_i = (idq.size() == 0) && ($urandom_range(0, 30) == 0);
    end
    clear_i = 0; out_r_valid = 0;

    // async reset mid-burst
    in_req = '1; out_gnt = 1;
    for (int c = 0; c < 6; c++) begin
      out_r_valid = (idq.size() > 0);
      out_r_data = $urandom;
      step();
    end
    out_gnt = 0; out_r_valid = 0;
    #1 rst_ni = 0;
    #1;
    m_reset();
    chk("arst_gnt", in_gnt, 0);
    chk("arst_req", out_req, 1);
    chk("arst_add", out_add, in_add[0]);
    chk("arst_rv", in_r_valid, 0);
    #1 rst_ni = 1;
    @(negedge clk);
    in_req = '0; out_r_valid = 1; step();
    out_r_valid = 0;
    #1 chk("arst_err", err_o, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
